// File: rtl/asteroids_pkg.sv
// Shared heading/direction types and the 32-entry heading -> direction code table
// used by the ship heading controller and the asteroid spawner.
package asteroids_pkg;

  localparam int HEADING_W    = 5;
  localparam int DIR_W        = 6;
  localparam int NUM_HEADINGS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_HOLD  = 2'd2
  } fsm_state_e;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_L    = 2'd1,
    CMD_R    = 2'd2
  } cmd_e;

  // Both keys or neither held means no rotation.
  function automatic cmd_e decode_cmd(input logic left, input logic right);
    cmd_e c;
    case ({left, right})
      2'b10:   c = CMD_L;
      2'b01:   c = CMD_R;
      default: c = CMD_NONE;
    endcase
    return c;
  endfunction

  // First quadrant holds (|x|,|y|) pairs; each later quadrant is the previous
  // one rotated a quarter turn clockwise, so magnitudes swap on odd quadrants.
  function automatic logic [DIR_W-1:0] heading_to_dir(input logic [HEADING_W-1:0] idx);
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] mag_x;
    logic [1:0] mag_y;
    logic       x_neg;
    logic       y_up;
    case (idx[2:0])
      3'd0:    begin a = 2'd0; b = 2'd3; end
      3'd1:    begin a = 2'd1; b = 2'd3; end
      3'd2:    begin a = 2'd1; b = 2'd2; end
      3'd3:    begin a = 2'd2; b = 2'd3; end
      3'd4:    begin a = 2'd3; b = 2'd3; end
      3'd5:    begin a = 2'd3; b = 2'd2; end
      3'd6:    begin a = 2'd2; b = 2'd1; end
      3'd7:    begin a = 2'd3; b = 2'd1; end
      default: begin a = 2'd0; b = 2'd3; end
    endcase
    case (idx[4:3])
      2'd0: begin
        mag_x = a; mag_y = b; x_neg = 1'b0;         y_up = (b != 2'd0);
      end
      2'd1: begin
        mag_x = b; mag_y = a; x_neg = 1'b0;         y_up = 1'b0;
      end
      2'd2: begin
        mag_x = a; mag_y = b; x_neg = (a != 2'd0);  y_up = 1'b0;
      end
      2'd3: begin
        mag_x = b; mag_y = a; x_neg = (b != 2'd0);  y_up = (a != 2'd0);
      end
      default: begin
        mag_x = a; mag_y = b; x_neg = 1'b0;         y_up = (b != 2'd0);
      end
    endcase
    return {x_neg, mag_x, y_up, mag_y};
  endfunction

endpackage

// File: rtl/heading_to_dir_lut.sv
// Combinational heading index -> direction code ROM.
module heading_to_dir_lut
  import asteroids_pkg::*;
(
  input  logic [4:0] idx,
  output logic [5:0] dir
);

  assign dir = heading_to_dir(idx);

endmodule

// File: rtl/ship_heading_ctrl.sv
// Rotate-key driven ship heading: key synchronisers, press/auto-repeat FSM,
// draw-safe step application and registered direction code.
module ship_heading_ctrl
  import asteroids_pkg::*;
#(
  parameter int REPEAT_FRAMES = 4,
  parameter int RESET_HEADING = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rot_left,
  input  logic       rot_right,
  input  logic       frame_tick,
  input  logic       draw_busy,
  output logic [4:0] heading,
  output logic [5:0] direction,
  output logic       dir_changed
);

  localparam int CNT_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_FRAMES - 1);
  localparam logic [HEADING_W-1:0] HEADING_INIT = HEADING_W'(RESET_HEADING);

  logic                 left_meta_q, left_sync_q;
  logic                 right_meta_q, right_sync_q;
  cmd_e                 cmd;
  cmd_e                 cmd_prev_q;
  logic                 cmd_changed;
  fsm_state_e           state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 step_req;
  logic                 step_right;
  logic                 pend_q, pend_d;
  logic                 pend_right_q, pend_right_d;
  logic                 apply;
  logic                 apply_right;
  logic [HEADING_W-1:0] heading_q, heading_d;
  logic [DIR_W-1:0]     direction_q, direction_d;
  logic                 dir_changed_q, dir_changed_d;

  assign cmd         = decode_cmd(left_sync_q, right_sync_q);
  assign cmd_changed = (cmd != cmd_prev_q);
  assign step_right  = (cmd == CMD_R);

  // Press / auto-repeat FSM; a command change always restarts in FIRST and ignores that cycle's tick.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    step_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        count_d = {CNT_W{1'b0}};
        if (cmd != CMD_NONE) begin
          state_d = ST_FIRST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FIRST: begin
        count_d = {CNT_W{1'b0}};
        if (cmd == CMD_NONE) begin
          state_d = ST_IDLE;
        end else if (cmd_changed) begin
          state_d = ST_FIRST;
        end else if (frame_tick) begin
          step_req = 1'b1;
          state_d  = ST_HOLD;
        end else begin
          state_d = ST_FIRST;
        end
      end
      ST_HOLD: begin
        if (cmd == CMD_NONE) begin
          state_d = ST_IDLE;
          count_d = {CNT_W{1'b0}};
        end else if (cmd_changed) begin
          state_d = ST_FIRST;
          count_d = {CNT_W{1'b0}};
        end else if (frame_tick) begin
          if (count_q == CNT_LAST) begin
            step_req = 1'b1;
            count_d  = {CNT_W{1'b0}};
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // A pending step owns the slot until drawing stops; requests arriving meanwhile are dropped.
  always_comb begin
    pend_d       = pend_q;
    pend_right_d = pend_right_q;
    apply        = 1'b0;
    apply_right  = 1'b0;
    if (pend_q) begin
      if (!draw_busy) begin
        apply       = 1'b1;
        apply_right = pend_right_q;
        pend_d      = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (step_req) begin
      if (!draw_busy) begin
        apply       = 1'b1;
        apply_right = step_right;
      end else begin
        pend_d       = 1'b1;
        pend_right_d = step_right;
      end
    end else begin
      pend_d = 1'b0;
    end

    if (apply) begin
      heading_d = apply_right ? (heading_q + 5'd1) : (heading_q - 5'd1);
    end else begin
      heading_d = heading_q;
    end
    dir_changed_d = apply;
  end

  heading_to_dir_lut u_lut (
    .idx (heading_d),
    .dir (direction_d)
  );

  // All state registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      left_meta_q   <= 1'b0;
      left_sync_q   <= 1'b0;
      right_meta_q  <= 1'b0;
      right_sync_q  <= 1'b0;
      cmd_prev_q    <= CMD_NONE;
      state_q       <= ST_IDLE;
      count_q       <= {CNT_W{1'b0}};
      pend_q        <= 1'b0;
      pend_right_q  <= 1'b0;
      heading_q     <= HEADING_INIT;
      direction_q   <= heading_to_dir(HEADING_INIT);
      dir_changed_q <= 1'b0;
    end else begin
      left_meta_q   <= rot_left;
      left_sync_q   <= left_meta_q;
      right_meta_q  <= rot_right;
      right_sync_q  <= right_meta_q;
      cmd_prev_q    <= cmd;
      state_q       <= state_d;
      count_q       <= count_d;
      pend_q        <= pend_d;
      pend_right_q  <= pend_right_d;
      heading_q     <= heading_d;
      direction_q   <= direction_d;
      dir_changed_q <= dir_changed_d;
    end
  end

  assign heading     = heading_q;
  assign direction   = direction_q;
  assign dir_changed = dir_changed_q;

endmodule

// File: tb/tb_ship_heading_ctrl.sv
// Self-checking bench for ship_heading_ctrl: directed scenarios plus randomized
// keys/ticks/busy checked every cycle against a run-based behavioural model.
module tb_ship_heading_ctrl;

  localparam int R_FRAMES = 4;
  localparam int R_HEAD   = 0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rot_left = 1'b0;
  logic       rot_right = 1'b0;
  logic       frame_tick = 1'b0;
  logic       draw_busy = 1'b0;
  logic [4:0] heading;
  logic [5:0] direction;
  logic       dir_changed;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  // Model state: 2-deep key delay line, current "run" of a steady command.
  int m_heading = R_HEAD;
  bit m_pend = 1'b0;
  bit m_pend_r = 1'b0;
  int m_prev_cmd = 0;
  bit m_p1l = 1'b0, m_p1r = 1'b0, m_p2l = 1'b0, m_p2r = 1'b0;
  int m_run = 0;
  bit m_dirch = 1'b0;

  int q1x[8] = '{0, 1, 1, 2, 3, 3, 2, 3};
  int q1y[8] = '{3, 3, 2, 3, 3, 2, 1, 1};

  ship_heading_ctrl #(.REPEAT_FRAMES(R_FRAMES), .RESET_HEADING(R_HEAD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rot_left    (rot_left),
    .rot_right   (rot_right),
    .frame_tick  (frame_tick),
    .draw_busy   (draw_busy),
    .heading     (heading),
    .direction   (direction),
    .dir_changed (dir_changed)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Vector geometry: rotate the first-quadrant (x,y) a quarter turn clockwise per quadrant.
  function automatic logic [5:0] ref_dir(input int idx);
    int x, y, t;
    x = q1x[idx % 8];
    y = q1y[idx % 8];
    for (int q = 0; q < idx / 8; q++) begin
      t = x; x = y; y = -t;
    end
    return {(x < 0) ? 1'b1 : 1'b0, 2'(x < 0 ? -x : x),
            (y > 0) ? 1'b1 : 1'b0, 2'(y < 0 ? -y : y)};
  endfunction

  function automatic int dec(input bit l, input bit r);
    if (l && !r) return 1;
    if (r && !l) return 2;
    return 0;
  endfunction

  task automatic model_edge();
    int cmd;
    bit req, req_r, app, app_r;
    if (!reset_n) begin
      m_heading = R_HEAD; m_pend = 1'b0; m_pend_r = 1'b0; m_prev_cmd = 0;
      m_p1l = 1'b0; m_p1r = 1'b0; m_p2l = 1'b0; m_p2r = 1'b0;
      m_run = 0; m_dirch = 1'b0;
    end else begin
      cmd = dec(m_p2l, m_p2r);
      req = 1'b0; req_r = 1'b0; app = 1'b0; app_r = 1'b0;
      if (cmd != m_prev_cmd) begin
        m_run = 0;
      end else if (cmd != 0 && frame_tick) begin
        if (m_run % R_FRAMES == 0) begin
          req = 1'b1; req_r = (cmd == 2);
        end
        m_run++;
      end
      if (m_pend) begin
        if (!draw_busy) begin app = 1'b1; app_r = m_pend_r; m_pend = 1'b0; end
      end else if (req) begin
        if (!draw_busy) begin app = 1'b1; app_r = req_r; end
        else begin m_pend = 1'b1; m_pend_r = req_r; end
      end
      if (app) m_heading = (m_heading + (app_r ? 1 : 31)) % 32;
      m_dirch = app;
      m_p2l = m_p1l; m_p2r = m_p1r; m_p1l = rot_left; m_p1r = rot_right;
      m_prev_cmd = cmd;
    end
  endtask

  task automatic cycle();
    bit legal;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("heading", int'(heading), m_heading);
    check("direction", int'(direction), int'(ref_dir(m_heading)));
    check("dir_changed", int'(dir_changed), int'(m_dirch));
    legal = 1'b0;
    for (int i = 0; i < 32; i++) if (ref_dir(i) == direction) legal = 1'b1;
    check("legal_code", int'(legal), 1);
    if (dir_changed) pulses++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic frame(input int gap);
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    run(gap);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
    cycle();
  endtask

  initial begin : stim
    int got;
    int seen;
    @(negedge clk);
    do_reset();
    check("t1_reset_heading", int'(heading), 0);
    check("t1_reset_dir", int'(direction), 'h07);
    pulses = 0;
    repeat (10) frame(4);
    check("t1_no_pulse", pulses, 0);
    check("t1_heading", int'(heading), 0);

    rot_right = 1'b1; run(4); pulses = 0;
    frame(2);
    check("t2_heading1", int'(heading), 1);
    check("t2_dir1", int'(direction), 'h0F);
    check("t2_pulse", pulses, 1);
    repeat (8) frame(2);
    check("t2_heading3", int'(heading), 3);
    rot_right = 1'b0; run(5);

    do_reset();
    rot_left = 1'b1; run(4); frame(2); rot_left = 1'b0; run(5);
    check("t3_wrap_down", int'(heading), 31);
    check("t3_dir31", int'(direction), 'h2F);
    rot_right = 1'b1; run(4); frame(2); rot_right = 1'b0; run(5);
    check("t3_wrap_up", int'(heading), 0);
    check("t3_dir0", int'(direction), 'h07);

    rot_right = 1'b1; run(4); draw_busy = 1'b1; pulses = 0;
    repeat (5) frame(9);
    check("t4_busy_hold", int'(heading), 0);
    check("t4_busy_pulses", pulses, 0);
    rot_right = 1'b0; draw_busy = 1'b0;
    cycle();
    check("t4_after_busy", int'(heading), 1);
    check("t4_pulse", int'(dir_changed), 1);
    run(10);
    check("t4_second_dropped", int'(heading), 1);

    rot_left = 1'b1; rot_right = 1'b1; run(4);
    repeat (20) frame(2);
    check("t5_both_keys", int'(heading), 1);
    rot_left = 1'b0; run(4); frame(2);
    check("t5_release_left", int'(heading), 2);
    rot_right = 1'b0; run(5);

    rot_right = 1'b1; run(4); draw_busy = 1'b1; frame(1);
    check("t6_pre_reset", int'(heading), 2);
    reset_n = 1'b0; cycle(); reset_n = 1'b1;
    rot_right = 1'b0; run(5);
    draw_busy = 1'b0; pulses = 0; run(5);
    check("t6_heading", int'(heading), R_HEAD);
    check("t6_no_pulse", pulses, 0);

    do_reset();
    rot_right = 1'b1; run(4);
    seen = 0;
    for (int s = 0; s < 32; s++) begin
      got = 0;
      for (int k = 0; k < 40 && got == 0; k++) begin
        frame_tick = (k % 2 == 0);
        cycle();
        if (dir_changed) got = 1;
      end
      frame_tick = 1'b0;
      check("sweep_step", got, 1);
      check("sweep_idx", int'(heading), (s + 1) % 32);
      case ((s + 1) % 32)
        0:  check("sweep_ref0", int'(direction), 'h07);
        1:  check("sweep_ref1", int'(direction), 'h0F);
        8:  check("sweep_ref8", int'(direction), 'h18);
        16: check("sweep_ref16", int'(direction), 'h03);
        24: check("sweep_ref24", int'(direction), 'h38);
        31: check("sweep_ref31", int'(direction), 'h2F);
        default: seen++;
      endcase
    end
    check("sweep_other_idx", seen, 26);
    rot_right = 1'b0; run(5);

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) rot_left = ~rot_left;
      if ($urandom_range(0, 29) == 0) rot_right = ~rot_right;
      if ($urandom_range(0, 11) == 0) draw_busy = ~draw_busy;
      frame_tick = ($urandom_range(0, 5) == 0);
      reset_n = ($urandom_range(0, 499) != 0);
      cycle();
    end
    frame_tick = 1'b0; reset_n = 1'b1; rot_left = 1'b0; rot_right = 1'b0; draw_busy = 1'b0;
    run(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
